// File: rtl/life_ctrl_4x4.sv
// life_ctrl_4x4: seeds a 4x4 life array one cell per cycle, then steps it at a fixed period
// until still-life, extinction, a generation limit or stop. `LIFE_CTRL_OSC_EN adds period-2 detection.
`timescale 1ns/1ps
module life_ctrl_4x4 #(
  parameter int TICK_DIV = 4,
  parameter int GEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      load_pattern,
  input  logic             load_req,
  output logic             load_ack,
  input  logic             start,
  input  logic             stop,
  input  logic [GEN_W-1:0] max_gens,
  input  logic [15:0]      alive,
  output logic [1:0]       row,
  output logic [1:0]       col,
  output logic             val,
  output logic             write_enb,
  output logic             run,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             done,
  output logic             stable,
  output logic             extinct,
  output logic             osc
);
  localparam int                WAIT_W    = $clog2(TICK_DIV);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TICK_DIV - 3);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN_WAIT, S_RUN_STEP, S_CHECK, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_pattern, r_prev;
  logic [3:0]        r_idx;
  logic [WAIT_W-1:0] r_wait;
  logic [GEN_W-1:0]  r_gen;
  logic              r_busy, r_done, r_stable, r_extinct;
  logic              w_idle_like, w_accept, w_start, w_stop;
  logic              w_set_stable, w_set_extinct;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept    = !reset && load_req && w_idle_like;
  // load_req has priority over a simultaneous start
  assign w_start     = start && !load_req && w_idle_like;
  assign w_stop      = stop && (r_state inside {S_RUN_WAIT, S_RUN_STEP, S_CHECK});

`ifdef LIFE_CTRL_OSC_EN
  logic [15:0] r_prev2;
  logic        r_osc, w_set_osc, w_osc_hit;
  assign w_osc_hit = (r_gen >= GEN_W'(2)) && (alive == r_prev2);
  assign osc       = r_osc;
`else
  assign osc = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    w_state_nxt   = r_state;
    w_set_stable  = 1'b0;
    w_set_extinct = 1'b0;
`ifdef LIFE_CTRL_OSC_EN
    w_set_osc     = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)     w_state_nxt = S_LOAD;
        else if (w_start) w_state_nxt = S_RUN_WAIT;
      end
      S_LOAD:     if (r_idx == 4'd15) w_state_nxt = S_IDLE;
      S_RUN_WAIT: begin
        if (w_stop)                  w_state_nxt = S_IDLE;
        else if (r_wait == WAIT_LAST) w_state_nxt = S_RUN_STEP;
      end
      S_RUN_STEP: w_state_nxt = w_stop ? S_IDLE : S_CHECK;
      S_CHECK: begin
        if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (alive == 16'h0000) begin
          w_set_extinct = 1'b1;
          w_state_nxt   = S_DONE;
        end else if (alive == r_prev) begin
          w_set_stable = 1'b1;
          w_state_nxt  = S_DONE;
`ifdef LIFE_CTRL_OSC_EN
        end else if (w_osc_hit) begin
          w_set_osc   = 1'b1;
          w_state_nxt = S_DONE;
`endif
        end else if ((max_gens != '0) && (r_gen == max_gens)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      r_state   <= S_IDLE;
      r_pattern <= '0;
      r_prev    <= '0;
      r_idx     <= '0;
      r_wait    <= '0;
      r_gen     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_stable  <= 1'b0;
      r_extinct <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= !(w_state_nxt inside {S_IDLE, S_DONE});
      r_done  <= (w_state_nxt == S_DONE);
      r_idx   <= (r_state == S_LOAD) ? r_idx + 4'd1 : 4'd0;
      r_wait  <= (r_state == S_RUN_WAIT) ? r_wait + WAIT_W'(1) : '0;
      if (w_accept) begin
        r_pattern <= load_pattern;
        r_gen     <= '0;
      end
      if (w_accept || w_start) begin
        r_stable  <= 1'b0;
        r_extinct <= 1'b0;
      end else begin
        r_stable  <= r_stable  | w_set_stable;
        r_extinct <= r_extinct | w_set_extinct;
      end
      // Snapshot the pre-step generation; the array updates on this same edge
      if (r_state == S_RUN_STEP) begin
        r_prev <= alive;
        if (r_gen != '1) r_gen <= r_gen + GEN_W'(1);
      end
    end
  end

`ifdef LIFE_CTRL_OSC_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev2 <= '0;
      r_osc   <= 1'b0;
    end else begin
      if (r_state == S_RUN_STEP) r_prev2 <= r_prev;
      if (w_accept || w_start) r_osc <= 1'b0;
      else                     r_osc <= r_osc | w_set_osc;
    end
  end
`endif

  assign load_ack  = w_accept;
  assign write_enb = (r_state == S_LOAD);
  assign col       = write_enb ? r_idx[3:2] : 2'b00;
  assign row       = write_enb ? r_idx[1:0] : 2'b00;
  assign val       = write_enb & r_pattern[r_idx];
  assign run       = (r_state == S_RUN_STEP);
  assign busy      = r_busy;
  assign gen_count = r_gen;
  assign done      = r_done;
  assign stable    = r_stable;
  assign extinct   = r_extinct;

endmodule

// File: tb/tb_life_ctrl_4x4.sv
// Scoreboard bench for life_ctrl_4x4: a behavioural 4x4 life array drives alive, and a
// generation-history model predicts each run's outcome (honours `LIFE_CTRL_OSC_EN).
`timescale 1ns/1ps
module tb_life_ctrl_4x4;
  localparam int TICK_DIV = 4;
  localparam int GEN_W    = 16;

  typedef struct packed { logic [1:0] row; logic [1:0] col; logic val; } wr_t;
  typedef struct packed { logic [GEN_W-1:0] gen; logic stb; logic ext; logic osc; } res_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [15:0]      load_pattern;
  logic             load_req, start, stop;
  logic [GEN_W-1:0] max_gens;
  logic [15:0]      arr = '0;
  logic             load_ack, val, write_enb, run, busy, done, stable, extinct, osc;
  logic [1:0]       row, col;
  logic [GEN_W-1:0] gen_count;

  int n_chk = 0;
  int n_err = 0;

  bit   ack_q[$];
  wr_t  wr_q[$];
  res_t res_q[$];

  logic [15:0] hist[$];
  int          model_gen = 0;

  life_ctrl_4x4 #(.TICK_DIV(TICK_DIV), .GEN_W(GEN_W)) dut (
    .clk(clk), .reset(reset), .load_pattern(load_pattern), .load_req(load_req),
    .load_ack(load_ack), .start(start), .stop(stop), .max_gens(max_gens), .alive(arr),
    .row(row), .col(col), .val(val), .write_enb(write_enb), .run(run), .busy(busy),
    .gen_count(gen_count), .done(done), .stable(stable), .extinct(extinct), .osc(osc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] life_next(input logic [15:0] p);
    logic [15:0] q;
    int n;
    q = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        n = 0;
        for (int dc = -1; dc <= 1; dc++)
          for (int dr = -1; dr <= 1; dr++)
            if ((dc != 0 || dr != 0) && c + dc >= 0 && c + dc < 4 && r + dr >= 0 && r + dr < 4)
              n += int'(p[(c + dc) * 4 + (r + dr)]);
        q[c * 4 + r] = (n == 3) || (p[c * 4 + r] && n == 2);
      end
    end
    return q;
  endfunction

  // The 4x4 array the controller talks to; not cleared by the controller's reset
  always @(posedge clk) begin
    if (write_enb)  arr[{col, row}] <= val;
    else if (run)   arr <= life_next(arr);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event
  int   cyc = 0, start_cyc = 0, last_run = -1, run_cnt = 0;
  logic done_d = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (load_req === 1'b1 || load_ack === 1'b1) begin
      if (ack_q.size() == 0) check("ack_unexpected", load_ack, 0);
      else begin
        check("load_ack", load_ack, ack_q[0]);
        void'(ack_q.pop_front());
      end
    end
    if (write_enb === 1'b1) begin
      if (wr_q.size() == 0) check("write_unexpected", 1, 0);
      else begin
        check("write_cell", {row, col, val}, {wr_q[0].row, wr_q[0].col, wr_q[0].val});
        void'(wr_q.pop_front());
      end
    end
    if (start === 1'b1 && load_req === 1'b0) begin
      start_cyc <= cyc;
      last_run  <= -1;
    end
    if (run === 1'b1) begin
      run_cnt <= run_cnt + 1;
      if (last_run < 0) check("first_run_delay", cyc - start_cyc, TICK_DIV - 1);
      else              check("run_period", cyc - last_run, TICK_DIV);
      last_run <= cyc;
    end
    if (done === 1'b1 && done_d !== 1'b1) begin
      if (res_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        check("done_gen", gen_count, res_q[0].gen);
        check("done_flags", {stable, extinct, osc}, {res_q[0].stb, res_q[0].ext, res_q[0].osc});
        void'(res_q.pop_front());
      end
    end
    done_d <= done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk generations from the model history until an exit rule fires
  task automatic predict(input int maxg, input bit commit, output int steps);
    int   base, g;
    bit   ended;
    res_t r;
    logic [15:0] nxt;
    base = hist.size(); g = model_gen; ended = 0; steps = 0; r = '0;
    for (int k = 0; k < 60 && !ended; k++) begin
      g++;
      nxt = life_next(hist[g - 1]);
      hist.push_back(nxt);
      steps++;
      r = '0;
      r.gen = GEN_W'(g);
      if (nxt == 16'h0)                 begin r.ext = 1; ended = 1; end
      else if (nxt == hist[g - 1])      begin r.stb = 1; ended = 1; end
`ifdef LIFE_CTRL_OSC_EN
      else if (g >= 2 && nxt == hist[g - 2]) begin r.osc = 1; ended = 1; end
`endif
      else if (maxg != 0 && g == maxg)  ended = 1;
    end
    if (commit && ended) begin
      res_q.push_back(r);
      model_gen = g;
    end else begin
      while (hist.size() > base) void'(hist.pop_back());
    end
    if (!ended) steps = -1;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done !== 1'b1 && k < bound) begin tick(); k++; end
    check("done_within_bound", done, 1);
    if (done !== 1'b1) begin
      stop = 1; tick(); stop = 0;
      res_q.delete();
    end
    tick();
  endtask

  task automatic do_load(input logic [15:0] pat, input bit with_start);
    wr_t w;
    load_pattern = pat; load_req = 1; start = with_start;
    ack_q.push_back(1'b1);
    for (int k = 0; k < 16; k++) begin
      w.row = 2'(k % 4); w.col = 2'(k / 4); w.val = pat[k];
      wr_q.push_back(w);
    end
    hist.delete(); hist.push_back(pat); model_gen = 0;
    tick();
    load_req = 0; start = 0;
    repeat (16) tick();
    check("load_writes_left", wr_q.size(), 0);
    check("load_busy_clear", busy, 0);
    check("array_after_load", arr, pat);
    check("gen_after_load", gen_count, 0);
  endtask

  task automatic do_run(input int maxg);
    int steps;
    predict(maxg, 1, steps);
    if (steps < 0) steps = 60;
    max_gens = GEN_W'(maxg);
    start = 1; tick(); start = 0;
    wait_done((steps + 1) * TICK_DIV + 8);
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, steps, maxg;
    reset = 1; load_pattern = '0; load_req = 0; start = 0; stop = 0; max_gens = '0;
    repeat (3) tick();
    reset = 0;
    check("reset_outputs", {load_ack, row, col, val, write_enb, run, busy, gen_count,
                            done, stable, extinct, osc}, 0);

    do_load(16'hA5C3, 0);
    do_load(16'h0660, 0);  do_run(0);
    do_load(16'h0001, 0);  do_run(0);
    do_load(16'h0070, 0);  do_run(5);

    // stop in RUN_WAIT, with a load_req while busy that must be ignored
    max_gens = '0; load_pattern = 16'hFFFF;
    start = 1; tick(); start = 0;
    load_req = 1; ack_q.push_back(1'b0); tick(); load_req = 0;
    stop = 1; snap = run_cnt; tick(); stop = 0;
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    repeat (3 * TICK_DIV) tick();
    check("stop_no_run", run_cnt, snap);
    check("stop_gen_kept", gen_count, model_gen);

    // load_req and start together: load wins, no stepping
    snap = run_cnt;
    do_load(16'h0660, 1);
    repeat (2 * TICK_DIV) tick();
    check("load_start_no_run", run_cnt, snap);
    check("load_start_idle", busy, 0);

    for (int it = 0; it < 24; it++) begin
      if (it == 0 || $urandom_range(0, 2) == 0) do_load(16'($urandom), 0);
      predict(0, 0, steps);
      if (steps >= 0 && steps <= 20 && $urandom_range(0, 1) == 1) maxg = 0;
      else maxg = model_gen + int'($urandom_range(1, 6));
      do_run(maxg);
    end

    // reset while the LOAD index is 7
    load_pattern = 16'hFFFF; load_req = 1; ack_q.push_back(1'b1);
    for (int k = 0; k < 16; k++) wr_q.push_back(wr_t'{row: 2'(k % 4), col: 2'(k / 4), val: 1'b1});
    tick(); load_req = 0;
    repeat (7) tick();
    reset = 1; tick(); reset = 0;
    check("reset_midload_outputs", {load_ack, row, col, val, write_enb, run, busy, gen_count,
                                    done, stable, extinct, osc}, 0);
    check("reset_midload_writes_left", wr_q.size(), 8);
    wr_q.delete();
    repeat (3) tick();
    check("reset_midload_idle", {busy, write_enb, run}, 0);

    repeat (4) tick();
    check("results_drained", res_q.size(), 0);
    check("acks_drained", ack_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/life_ctrl_4x4.md
Name: life_ctrl_4x4

Overview:
Upstream controller for the 4x4 life array. It loads a 16-bit seed pattern into the array one cell per cycle using the array's row/col/val/write_enb port. It then steps generations by pulsing the array's run input at a fixed period. After each step it watches the array's alive vector and ends the run on still-life, extinction, or a generation limit.

Parameters:
TICK_DIV, 4, generation period in clk cycles; legal range is 3 and up.
GEN_W, 16, width of the generation counter and of max_gens.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load_pattern  in  16  seed pattern; bit index = col*4+row, same packing as the array's alive vector
load_req  in  1  request to load load_pattern
load_ack  out  1  one-cycle pulse when a load request is accepted
start  in  1  begin stepping generations
stop  in  1  abort stepping
max_gens  in  GEN_W  generation limit; 0 means unlimited
alive  in  16  alive vector from the array
row  out  2  cell row to the array
col  out  2  cell column to the array
val  out  1  cell value to the array
write_enb  out  1  cell write strobe to the array
run  out  1  generation-step enable to the array
busy  out  1  high in any state other than IDLE and DONE
gen_count  out  GEN_W  number of generations stepped since the last load
done  out  1  run finished; held until the next load or start
stable  out  1  run ended because the pattern did not change
extinct  out  1  run ended because all cells are dead

Behaviour:
- Reset value of every output is 0. After reset the FSM is in IDLE.
- States: IDLE, LOAD, RUN_WAIT, RUN_STEP, CHECK, DONE.
- Load acceptance:
  - In IDLE or DONE, load_req=1 latches load_pattern and pulses load_ack for that cycle. The FSM goes to LOAD next cycle.
  - On acceptance, gen_count, done, stable and extinct clear.
  - load_req in any other state is ignored; load_ack stays 0.
- LOAD state:
  - Lasts exactly 16 cycles, cell index idx = 0..15.
  - Each cycle: write_enb=1, col=idx[3:2], row=idx[1:0], val=pattern[idx].
  - After idx=15 the FSM returns to IDLE.
  - Outside LOAD, write_enb=0 and row/col/val are 0.
- Start:
  - start=1 in IDLE or DONE enters RUN_WAIT. done, stable and extinct clear.
  - gen_count is kept, so a run continues from the current generation.
  - If load_req and start are both high in the same cycle, load_req wins and start is ignored.
- RUN_WAIT:
  - Lasts TICK_DIV-2 cycles, then goes to RUN_STEP.
- RUN_STEP:
  - Lasts one cycle with run=1.
  - Snapshots alive into prev (the pre-step value).
  - Increments gen_count; gen_count saturates at all-ones.
- CHECK:
  - Lasts one cycle; samples alive, which now holds the updated generation.
  - Exit conditions are checked in priority order:
    1. alive==0: extinct=1, go to DONE.
    2. alive==prev: stable=1, go to DONE.
    3. max_gens!=0 and gen_count==max_gens: go to DONE.
    4. Otherwise go to RUN_WAIT.
- Timing:
  - run pulses exactly once every TICK_DIV cycles.
  - The first pulse is TICK_DIV-1 cycles after the cycle in which start is sampled.
- DONE:
  - done=1 is held. busy=0.
- stop:
  - stop=1 in RUN_WAIT, RUN_STEP or CHECK goes to IDLE next cycle.
  - A run pulse already asserted in that cycle completes, but no exit flags are set. gen_count keeps its value.
  - stop has no effect in other states.
- busy is a registered decode of the state.
- Reset in any state, including mid-LOAD, returns the FSM to IDLE with all outputs 0. The partially written array is not cleared.

Optional Feature:
LIFE_CTRL_OSC_EN:
- Adds a second snapshot, prev2, holding alive from two generations back, and an output port osc (1 bit).
- In CHECK, after the stable test and before the limit test: if gen_count>=2 and alive==prev2, set osc=1 and go to DONE. This detects period-2 oscillators.
- osc clears under the same conditions as stable.
- Without the macro: no prev2 register; osc is present but tied to 0; period-2 patterns run until max_gens or stop.

Test Plan:
- Load: load_req with load_pattern=16'hA5C3 → load_ack pulse, then 16 consecutive writes; at idx k, write_enb=1 and val=bit k, with col/row = k[3:2]/k[1:0]. Array alive==16'hA5C3 afterwards.
- Still life: load 16'h0660 (2x2 block), start, max_gens=0 → one run pulse, then done=1, stable=1, extinct=0, gen_count=1.
- Extinction: load 16'h0001, start → after the first step alive==0; done=1, extinct=1, stable=0, gen_count=1.
- Blinker with limit: load 16'h0070, max_gens=5, macro off → alive alternates 0x0222/0x0070; done after 5 pulses, gen_count=5, flags 0. Pulses are spaced exactly TICK_DIV=4 cycles apart.
- Blinker with LIFE_CTRL_OSC_EN: same stimulus → done at gen_count=2, osc=1.
- Stop and conflicts: stop during RUN_WAIT → IDLE next cycle, no further run pulses. load_req while busy → no load_ack. load_req and start together in IDLE → load performed, no run.
- Reset mid-LOAD at idx=7: all outputs 0 next cycle, FSM in IDLE.
